// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and its consumers (decode/controller).
// Instruction fields: TYP is the top bit, OP is the next four bits.
package fetch_unit_pkg;

   localparam int INSTR_W = 9;
   localparam int TYP_BIT = INSTR_W - 1;
   localparam int OP_MSB  = INSTR_W - 2;
   localparam int OP_LSB  = INSTR_W - 5;
   localparam int OP_W    = 4;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      ISSUE = 3'd3,
      DONE  = 3'd4
   } fetch_state_t;

   // Command to the program counter for the coming edge.
   typedef enum logic [1:0] {
      PC_HOLD   = 2'd0,
      PC_START  = 2'd1,
      PC_BRANCH = 2'd2,
      PC_INCR   = 2'd3
   } pc_cmd_t;

   // Saturating 16-bit increment used by the performance counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      logic [15:0] result;
      if (value == 16'hFFFF) begin
         result = value;
      end else begin
         result = value + 16'd1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fetch_unit_program_counter.sv
// Program counter for the fetch stage: load (start address or branch target),
// increment with natural wrap modulo 2^PC_W, or hold. Also flags LAST_ADDR.
module program_counter
   import fetch_unit_pkg::*;
#(
   parameter int PC_W       = 10,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 1023
) (
   input  logic            clk,
   input  logic            reset,
   input  pc_cmd_t         cmd,
   input  logic [PC_W-1:0] br_target,
   output logic [PC_W-1:0] pc,
   output logic            at_last
);

   localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
   localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_ADDR);
   localparam logic [PC_W-1:0] ONE_PC   = PC_W'(1);

   logic [PC_W-1:0] pc_r;

   // PC register; the increment wraps because the adder is exactly PC_W wide.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_r <= START_PC;
      end else begin
         case (cmd)
            PC_START:  pc_r <= START_PC;
            PC_BRANCH: pc_r <= br_target;
            PC_INCR:   pc_r <= pc_r + ONE_PC;
            default:   pc_r <= pc_r;
         endcase
      end
   end

   assign pc      = pc_r;
   assign at_last = (pc_r == LAST_PC);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and issue stage: one outstanding imem read per
// instruction (FETCH -> LATCH -> ISSUE), valid/ready handoff to decode,
// branch redirect on the accepting cycle.
// Optional build macro FETCH_PERF_EN adds saturating instr_count/br_count.
module fetch_unit #(
   parameter int PC_W       = 10,
   parameter int INSTR_W    = fetch_unit_pkg::INSTR_W,
   parameter int START_ADDR = 0,
   parameter int LAST_ADDR  = 1023
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   input  logic               halt,
   output logic [PC_W-1:0]    imem_addr,
   output logic               imem_rd_en,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               TYP,
   output logic [3:0]         OP,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               br_ctrl,
   input  logic [PC_W-1:0]    br_target,
   output logic [PC_W-1:0]    pc,
   output logic               done
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        instr_count,
   output logic [15:0]        br_count
`endif
);

   import fetch_unit_pkg::*;

   fetch_state_t       state_r;
   fetch_state_t       state_s;
   pc_cmd_t            pc_cmd_s;
   logic               accept_s;
   logic               at_last_s;
   logic [INSTR_W-1:0] instr_r;
   logic               instr_valid_r;
   logic               imem_rd_en_r;
   logic               done_r;

   program_counter #(
      .PC_W       (PC_W),
      .START_ADDR (START_ADDR),
      .LAST_ADDR  (LAST_ADDR)
   ) u_pc (
      .clk       (CLK),
      .reset     (reset),
      .cmd       (pc_cmd_s),
      .br_target (br_target),
      .pc        (pc),
      .at_last   (at_last_s)
   );

   // Next-state and PC command; halt/branch only matter on an accept.
   always_comb begin
      state_s  = state_r;
      pc_cmd_s = PC_HOLD;
      accept_s = 1'b0;
      case (state_r)
         IDLE, DONE: begin
            if (start) begin
               state_s  = FETCH;
               pc_cmd_s = PC_START;
            end else begin
               state_s  = state_r;
            end
         end
         FETCH: state_s = LATCH;
         LATCH: state_s = ISSUE;
         ISSUE: begin
            accept_s = instr_valid_r & instr_ready;
            if (accept_s) begin
               if (br_ctrl) begin
                  pc_cmd_s = PC_BRANCH;
               end else begin
                  pc_cmd_s = PC_INCR;
               end
               if (halt) begin
                  state_s = DONE;
               end else if (!br_ctrl && at_last_s) begin
                  state_s = DONE;
               end else begin
                  state_s = FETCH;
               end
            end else begin
               state_s = ISSUE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State plus registered outputs, decoded from the state being entered.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_r       <= IDLE;
         instr_r       <= '0;
         instr_valid_r <= 1'b0;
         imem_rd_en_r  <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         instr_valid_r <= (state_s == ISSUE);
         imem_rd_en_r  <= (state_s == FETCH);
         done_r        <= (state_s == DONE);
         if (state_r == LATCH) begin
            instr_r <= imem_data;
         end else begin
            instr_r <= instr_r;
         end
      end
   end

   assign imem_addr   = pc;
   assign imem_rd_en  = imem_rd_en_r;
   assign instr       = instr_r;
   assign TYP         = instr_r[INSTR_W-1];
   assign OP          = instr_r[INSTR_W-2 -: 4];
   assign instr_valid = instr_valid_r;
   assign done        = done_r;

`ifdef FETCH_PERF_EN
   logic [15:0] instr_count_r;
   logic [15:0] br_count_r;

   // Saturating accept/branch counters, cleared by reset and an accepted start.
   always_ff @(posedge CLK) begin
      if (reset) begin
         instr_count_r <= 16'd0;
         br_count_r    <= 16'd0;
      end else if (pc_cmd_s == PC_START) begin
         instr_count_r <= 16'd0;
         br_count_r    <= 16'd0;
      end else if (accept_s) begin
         instr_count_r <= sat_inc16(instr_count_r);
         if (br_ctrl) begin
            br_count_r <= sat_inc16(br_count_r);
         end else begin
            br_count_r <= br_count_r;
         end
      end else begin
         instr_count_r <= instr_count_r;
         br_count_r    <= br_count_r;
      end
   end

   assign instr_count = instr_count_r;
   assign br_count    = br_count_r;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed steps followed by a random program walk,
// checked against a transaction-level model of the PC/program rules.
module tb_fetch_unit;

   localparam int PC_W    = 10;
   localparam int INSTR_W = 9;
   localparam int LAST    = 3;

   logic               CLK = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               halt = 1'b0;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_rd_en;
   logic [INSTR_W-1:0] imem_data = '0;
   logic [INSTR_W-1:0] instr;
   logic               TYP;
   logic [3:0]         OP;
   logic               instr_valid;
   logic               instr_ready = 1'b0;
   logic               br_ctrl = 1'b0;
   logic [PC_W-1:0]    br_target = '0;
   logic [PC_W-1:0]    pc;
   logic               done;
`ifdef FETCH_PERF_EN
   logic [15:0]        instr_count;
   logic [15:0]        br_count;
`endif

   fetch_unit #(
      .PC_W       (PC_W),
      .INSTR_W    (INSTR_W),
      .START_ADDR (0),
      .LAST_ADDR  (LAST)
   ) dut (
      .CLK         (CLK),
      .reset       (reset),
      .start       (start),
      .halt        (halt),
      .imem_addr   (imem_addr),
      .imem_rd_en  (imem_rd_en),
      .imem_data   (imem_data),
      .instr       (instr),
      .TYP         (TYP),
      .OP          (OP),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .br_ctrl     (br_ctrl),
      .br_target   (br_target),
      .pc          (pc),
      .done        (done)
`ifdef FETCH_PERF_EN
      ,
      .instr_count (instr_count),
      .br_count    (br_count)
`endif
   );

   always #5 CLK = ~CLK;

   // Instruction memory: synchronous read, data appears the cycle after rd_en.
   logic [INSTR_W-1:0] mem [0:1023];
   always @(posedge CLK) begin
      if (imem_rd_en) imem_data <= mem[imem_addr];
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: program position and counters.
   int m_pc   = 0;
   bit m_done = 1'b0;
   int m_ic   = 0;
   int m_bc   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_counters(input string tag);
`ifdef FETCH_PERF_EN
      chk({tag, "_instr_count"}, {16'd0, instr_count}, m_ic);
      chk({tag, "_br_count"}, {16'd0, br_count}, m_bc);
`else
      n_tests = n_tests + 0;
`endif
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      m_pc   = 0;
      m_done = 1'b0;
      m_ic   = 0;
      m_bc   = 0;
      chk("start_done_clear", {31'd0, done}, 0);
      chk("start_valid", {31'd0, instr_valid}, 0);
      chk_counters("start");
   endtask

   // Called in a FETCH cycle: wait for issue, stall, then accept.
   task automatic issue(input int stall, input bit br, input logic [PC_W-1:0] tgt, input bit hlt);
      int n;
      int exp;
      chk("fetch_rd_en", {31'd0, imem_rd_en}, 1);
      chk("fetch_addr", {22'd0, imem_addr}, m_pc);
      n = 0;
      while (!instr_valid && n < 8) begin
         tick();
         n++;
      end
      chk("issue_latency", n, 2);
      exp = int'(mem[m_pc]);
      chk("instr", {23'd0, instr}, exp);
      chk("typ", {31'd0, TYP}, (exp >> 8) & 1);
      chk("op", {28'd0, OP}, (exp >> 4) & 15);
      chk("issue_pc", {22'd0, pc}, m_pc);
      chk("issue_rd_en", {31'd0, imem_rd_en}, 0);
      chk("issue_done", {31'd0, done}, 0);
      for (int i = 0; i < stall; i++) begin
         instr_ready = 1'b0;
         halt        = 1'b1;
         br_ctrl     = 1'($urandom % 2);
         start       = 1'($urandom % 2);
         br_target   = PC_W'($urandom);
         tick();
         chk("stall_valid", {31'd0, instr_valid}, 1);
         chk("stall_instr", {23'd0, instr}, exp);
         chk("stall_pc", {22'd0, pc}, m_pc);
         chk("stall_rd_en", {31'd0, imem_rd_en}, 0);
      end
      instr_ready = 1'b1;
      br_ctrl     = br;
      br_target   = tgt;
      halt        = hlt;
      start       = 1'b0;
      tick();
      instr_ready = 1'b0;
      br_ctrl     = 1'b0;
      halt        = 1'b0;
      m_done = hlt || (!br && m_pc == LAST);
      m_pc   = br ? int'(tgt) : (m_pc + 1) % 1024;
      if (m_ic < 65535) m_ic++;
      if (br && m_bc < 65535) m_bc++;
      chk("post_accept_valid", {31'd0, instr_valid}, 0);
      chk("post_accept_done", {31'd0, done}, {31'd0, m_done});
      chk("post_accept_pc", {22'd0, pc}, m_pc);
      chk_counters("accept");
   endtask

   task automatic check_done_hold();
      halt  = 1'b1;
      tick();
      halt  = 1'b0;
      chk("done_hold", {31'd0, done}, 1);
      chk("done_pc_frozen", {22'd0, pc}, m_pc);
      chk("done_quiet", {30'd0, imem_rd_en, instr_valid}, 0);
   endtask

   initial begin
      int stall;
      bit br;
      bit hlt;
      logic [PC_W-1:0] tgt;

      for (int i = 0; i < 1024; i++) mem[i] = INSTR_W'($urandom % 512);
      mem[0] = 9'h1AB;
      mem[1] = 9'h034;

      // Reset values
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_pc", {22'd0, pc}, 0);
      chk("rst_instr", {23'd0, instr}, 0);
      chk("rst_valid", {31'd0, instr_valid}, 0);
      chk("rst_rd_en", {31'd0, imem_rd_en}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk_counters("rst");
      tick();
      chk("idle_quiet", {30'd0, imem_rd_en, instr_valid}, 0);

      // Straight line, back-pressure, end of program at LAST
      do_start();
      issue(0, 1'b0, 10'd0, 1'b0);
      issue(0, 1'b0, 10'd0, 1'b0);
      issue(5, 1'b0, 10'd0, 1'b0);
      issue(0, 1'b0, 10'd0, 1'b0);
      chk("end_done", {31'd0, done}, 1);
      check_done_hold();

      // Branches, wrap, taken branch at LAST, halt on accept
      do_start();
      issue(0, 1'b1, 10'd5, 1'b0);
      issue(0, 1'b1, 10'h2F0, 1'b0);
      issue(1, 1'b0, 10'd0, 1'b0);
      issue(0, 1'b1, 10'd1023, 1'b0);
      issue(0, 1'b0, 10'd0, 1'b0);
      issue(0, 1'b1, 10'd3, 1'b0);
      issue(0, 1'b1, 10'd6, 1'b0);
      issue(2, 1'b0, 10'd0, 1'b0);
      issue(3, 1'b0, 10'd0, 1'b1);
      chk("halt_done", {31'd0, done}, 1);
      check_done_hold();

      // Random program walk
      for (int k = 0; k < 150; k++) begin
         if (m_done) do_start();
         stall = int'($urandom_range(0, 3));
         br    = ($urandom % 4) == 0;
         hlt   = ($urandom % 16) == 0;
         tgt   = ($urandom % 2 == 0) ? PC_W'($urandom_range(0, 7)) : PC_W'($urandom);
         issue(stall, br, tgt, hlt);
      end
      if (m_done) do_start();

      // Reset during LATCH with a non-reset pc and instr
      issue(0, 1'b1, 10'd9, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      m_pc = 0; m_done = 1'b0; m_ic = 0; m_bc = 0;
      chk("mid_rst_pc", {22'd0, pc}, 0);
      chk("mid_rst_instr", {23'd0, instr}, 0);
      chk("mid_rst_valid", {31'd0, instr_valid}, 0);
      chk("mid_rst_rd_en", {31'd0, imem_rd_en}, 0);
      chk("mid_rst_done", {31'd0, done}, 0);
      chk_counters("mid_rst");
      tick();
      chk("mid_rst_idle", {30'd0, imem_rd_en, instr_valid}, 0);
      do_start();
      issue(0, 1'b0, 10'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
